// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter and the SoC top:
// port index constants, byte-enable type, saturating increment helper.
package mem_arbiter_pkg;

   localparam logic ARB_P0 = 1'b0;
   localparam logic ARB_P1 = 1'b1;

   localparam int HOLD_W = 8;

   typedef logic [3:0] byte_en_t;

   function automatic logic [HOLD_W-1:0] sat_inc(
      input logic [HOLD_W-1:0] v,
      input logic [HOLD_W-1:0] lim
   );
      return (v >= lim) ? lim : v + 8'd1;
   endfunction

endpackage

// File: rtl/mem_arbiter_hold_counter.sv
// Saturating count of consecutive grants to one port while the other waits.
// Ports: clk, n_reset, grant/same_port/other_req (this cycle), cnt_q (count).
module mem_arbiter_hold_counter
   import mem_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 8
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              grant,
   input  logic              same_port,
   input  logic              other_req,
   output logic [HOLD_W-1:0] cnt_q
);

   localparam logic [HOLD_W-1:0] LIM = HOLD_W'(MAX_HOLD);

   logic [HOLD_W-1:0] cnt_d;

   // Counting only matters while the other port is kept waiting;
   // a switch of owner restarts the run at one.
   always_comb begin
      cnt_d = '0;
      if (grant && other_req) begin
         cnt_d = same_port ? sat_inc(cnt_q, LIM) : 8'd1;
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory bus arbiter: port 0 = UART debug, port 1 = CPU data.
// Ports: clk, n_reset, m0_*/m1_* requester buses, mem_* shared bus.
// Grant per cycle with lock and starvation limit; reads return the cycle
// after grant. Define MEM_ARBITER_RR_EN for round-robin tie breaking,
// otherwise port 0 wins ties.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MAX_HOLD = 8
) (
   input  logic          clk,
   input  logic          n_reset,
   input  logic          m0_req,
   input  logic          m0_lock,
   input  logic [AW-1:0] m0_adr,
   input  logic [DW-1:0] m0_wdata,
   input  byte_en_t      m0_wren,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_lock,
   input  logic [AW-1:0] m1_adr,
   input  logic [DW-1:0] m1_wdata,
   input  byte_en_t      m1_wren,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic          mem_op,
   output logic [AW-1:0] mem_adr,
   output logic [DW-1:0] mem_di,
   output byte_en_t      mem_wren,
   input  logic [DW-1:0] mem_do
);

   localparam logic [HOLD_W-1:0] LIM = HOLD_W'(MAX_HOLD);

   logic              last_q, last_d;
   logic              lock_q, lock_d;
   logic              rd_pend_q, rd_pend_d;
   logic              rd_port_q, rd_port_d;
   logic [HOLD_W-1:0] hold_q;

   logic [1:0] req;
   logic       other;
   logic       gnt_any;
   logic       sel;

   always_comb begin
      req     = {m1_req, m0_req};
      other   = ~last_q;
      gnt_any = 1'b0;
      sel     = last_q;
      // Grant is gated by reset so the bus idles the instant reset asserts.
      if (n_reset) begin
         if (hold_q == LIM && req[other]) begin
            gnt_any = 1'b1;
            sel     = other;
         end else if (lock_q && req[last_q]) begin
            gnt_any = 1'b1;
            sel     = last_q;
         end else if (req != 2'b00) begin
            gnt_any = 1'b1;
            case (req)
               2'b01:   sel = ARB_P0;
               2'b10:   sel = ARB_P1;
               default: begin
`ifdef MEM_ARBITER_RR_EN
                  sel = ~last_q;
`else
                  sel = ARB_P0;
`endif
               end
            endcase
         end
      end
   end

   assign m0_gnt = gnt_any & (sel == ARB_P0);
   assign m1_gnt = gnt_any & (sel == ARB_P1);
   assign mem_op = gnt_any;

   always_comb begin
      mem_adr  = '0;
      mem_di   = '0;
      mem_wren = '0;
      if (gnt_any) begin
         mem_adr  = sel ? m1_adr   : m0_adr;
         mem_di   = sel ? m1_wdata : m0_wdata;
         mem_wren = sel ? m1_wren  : m0_wren;
      end
   end

   always_comb begin
      last_d    = gnt_any ? sel : last_q;
      lock_d    = gnt_any & (sel ? m1_lock : m0_lock);
      rd_pend_d = gnt_any & (mem_wren == 4'b0000);
      rd_port_d = sel;
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         last_q    <= ARB_P1;
         lock_q    <= 1'b0;
         rd_pend_q <= 1'b0;
         rd_port_q <= ARB_P0;
      end else begin
         last_q    <= last_d;
         lock_q    <= lock_d;
         rd_pend_q <= rd_pend_d;
         rd_port_q <= rd_port_d;
      end
   end

   mem_arbiter_hold_counter #(
      .MAX_HOLD (MAX_HOLD)
   ) u_hold (
      .clk       (clk),
      .n_reset   (n_reset),
      .grant     (gnt_any),
      .same_port (sel == last_q),
      .other_req (req[~sel]),
      .cnt_q     (hold_q)
   );

   assign m0_rvalid = rd_pend_q & (rd_port_q == ARB_P0);
   assign m1_rvalid = rd_pend_q & (rd_port_q == ARB_P1);
   assign m0_rdata  = m0_rvalid ? mem_do : '0;
   assign m1_rdata  = m1_rvalid ? mem_do : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a rule-level model of the arbitration policy.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int MAXH = 8;
`ifdef MEM_ARBITER_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          n_reset = 1'b0;
   logic          m0_req, m0_lock, m1_req, m1_lock;
   logic [AW-1:0] m0_adr, m1_adr;
   logic [DW-1:0] m0_wdata, m1_wdata;
   byte_en_t      m0_wren, m1_wren;
   logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic          mem_op;
   logic [AW-1:0] mem_adr;
   logic [DW-1:0] mem_di;
   byte_en_t      mem_wren;
   logic [DW-1:0] mem_do;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   mem_arbiter #(
      .AW(AW), .DW(DW), .MAX_HOLD(MAXH)
   ) dut (
      .clk(clk), .n_reset(n_reset),
      .m0_req(m0_req), .m0_lock(m0_lock), .m0_adr(m0_adr),
      .m0_wdata(m0_wdata), .m0_wren(m0_wren), .m0_gnt(m0_gnt),
      .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_lock(m1_lock), .m1_adr(m1_adr),
      .m1_wdata(m1_wdata), .m1_wren(m1_wren), .m1_gnt(m1_gnt),
      .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_op(mem_op), .mem_adr(mem_adr), .mem_di(mem_di),
      .mem_wren(mem_wren), .mem_do(mem_do)
   );

   task automatic idle();
      m0_req = 0; m0_lock = 0; m0_adr = '0; m0_wdata = '0; m0_wren = '0;
      m1_req = 0; m1_lock = 0; m1_adr = '0; m1_wdata = '0; m1_wren = '0;
      mem_do = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle();
      n_reset = 0;
      @(negedge clk);
      n_reset = 1;
   endtask

   task automatic test_reset();
      logic [4:0] got;
      @(negedge clk);
      idle();
      n_reset = 0;
      m0_req = 1; m0_adr = 32'h100;
      m1_req = 1; m1_adr = 32'h200;
      mem_do = 32'hffff_ffff;
      #1;
      got = {m0_gnt, m1_gnt, mem_op, m0_rvalid, m1_rvalid};
      nchk++;
      if (got !== 5'b0) begin
         nerr++;
         $display("FAIL reset_ctl: got %b want 00000", got);
      end
      nchk++;
      if ({mem_adr, mem_di, mem_wren} !== '0) begin
         nerr++;
         $display("FAIL reset_bus: adr %h di %h wren %h want 0",
                  mem_adr, mem_di, mem_wren);
      end
      nchk++;
      if ({m0_rdata, m1_rdata} !== '0) begin
         nerr++;
         $display("FAIL reset_rdata: %h %h want 0", m0_rdata, m1_rdata);
      end
      @(negedge clk);
      idle();
      n_reset = 1;
   endtask

   task automatic test_read();
      do_reset();
      m1_req = 1; m1_adr = 32'h2_0000;
      #1;
      nchk++;
      if ({m1_gnt, m0_gnt, mem_op} !== 3'b101 || mem_adr !== 32'h2_0000) begin
         nerr++;
         $display("FAIL rd_grant: gnt %b%b op %b adr %h want 10 1 00020000",
                  m1_gnt, m0_gnt, mem_op, mem_adr);
      end
      @(negedge clk);
      m1_req = 0; mem_do = 32'h1234_5678;
      #1;
      nchk++;
      if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h1234_5678) begin
         nerr++;
         $display("FAIL rd_data: rvalid %b rdata %h want 1 12345678",
                  m1_rvalid, m1_rdata);
      end
      nchk++;
      if (m0_rvalid !== 1'b0 || m0_rdata !== '0 || mem_op !== 1'b0) begin
         nerr++;
         $display("FAIL rd_other: m0 %b %h op %b want 0 0 0",
                  m0_rvalid, m0_rdata, mem_op);
      end
      @(negedge clk);
      idle();
   endtask

   task automatic test_tie();
      int exp;
      do_reset();
      m0_req = 1; m0_adr = 32'h10;
      m1_req = 1; m1_adr = 32'h20;
      for (int i = 0; i < 20; i++) begin
         #1;
         exp = RR ? (i % 2) : ((i % 9 == 8) ? 1 : 0);
         nchk++;
         if ({m1_gnt, m0_gnt} !== (exp == 1 ? 2'b10 : 2'b01)) begin
            nerr++;
            $display("FAIL tie_c%0d: gnt %b%b want port %0d",
                     i, m1_gnt, m0_gnt, exp);
         end
         @(negedge clk);
      end
      idle();
   endtask

   task automatic test_lock();
      do_reset();
      m1_req = 1; m1_lock = 1; m1_adr = 32'h1_0010;
      m1_wren = 4'hf; m1_wdata = 32'hcafe_0001;
      for (int i = 0; i < 3; i++) begin
         #1;
         nchk++;
         if ({m1_gnt, m0_gnt} !== 2'b10 || mem_wren !== 4'hf ||
             mem_adr !== 32'h1_0010) begin
            nerr++;
            $display("FAIL lock_c%0d: gnt %b%b wren %h adr %h want 10 f 00010010",
                     i, m1_gnt, m0_gnt, mem_wren, mem_adr);
         end
         @(negedge clk);
         m0_req = 1; m0_adr = 32'h100;
      end
      m1_req = 0; m1_lock = 0;
      #1;
      nchk++;
      if ({m1_gnt, m0_gnt} !== 2'b01 || mem_adr !== 32'h100 ||
          m1_rvalid !== 1'b0) begin
         nerr++;
         $display("FAIL lock_release: gnt %b%b adr %h rv1 %b want 01 100 0",
                  m1_gnt, m0_gnt, mem_adr, m1_rvalid);
      end
      @(negedge clk);
      idle();
   endtask

   task automatic test_reset_mid();
      do_reset();
      m0_req = 1; m0_adr = 32'h40;
      #1;
      nchk++;
      if (m0_gnt !== 1'b1) begin
         nerr++;
         $display("FAIL rst_mid_gnt: got %b want 1", m0_gnt);
      end
      @(negedge clk);
      m0_req = 0; m1_req = 1; m1_adr = 32'h44;
      mem_do = 32'hdead_beef;
      #1;
      nchk++;
      if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hdead_beef ||
          mem_op !== 1'b1) begin
         nerr++;
         $display("FAIL rst_mid_pre: rv %b rd %h op %b want 1 deadbeef 1",
                  m0_rvalid, m0_rdata, mem_op);
      end
      #1 n_reset = 0;
      #1;
      nchk++;
      if (m0_rvalid !== 1'b0 || m0_rdata !== '0 || mem_op !== 1'b0 ||
          m1_gnt !== 1'b0) begin
         nerr++;
         $display("FAIL rst_mid_async: rv %b rd %h op %b g1 %b want 0 0 0 0",
                  m0_rvalid, m0_rdata, mem_op, m1_gnt);
      end
      @(negedge clk);
      n_reset = 1;
      m0_req = 1; m1_req = 1; mem_do = '0;
      #1;
      nchk++;
      if ({m1_gnt, m0_gnt} !== 2'b01 || m0_rvalid !== 1'b0) begin
         nerr++;
         $display("FAIL rst_mid_tie: gnt %b%b rv0 %b want 01 0",
                  m1_gnt, m0_gnt, m0_rvalid);
      end
      @(negedge clk);
      idle();
   endtask

   task automatic test_wr_then_rd();
      do_reset();
      m0_req = 1; m0_adr = 32'h8; m0_wren = 4'b0001; m0_wdata = 32'h0000_00a5;
      #1;
      nchk++;
      if (m0_gnt !== 1'b1 || mem_wren !== 4'b0001 || mem_di !== 32'ha5) begin
         nerr++;
         $display("FAIL wr_grant: g %b wren %b di %h want 1 0001 a5",
                  m0_gnt, mem_wren, mem_di);
      end
      @(negedge clk);
      idle();
      m1_req = 1; m1_adr = 32'h2_0004; mem_do = 32'haaaa_aaaa;
      #1;
      nchk++;
      if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || m1_gnt !== 1'b1) begin
         nerr++;
         $display("FAIL wr_norsp: rv %b%b g1 %b want 00 1",
                  m1_rvalid, m0_rvalid, m1_gnt);
      end
      @(negedge clk);
      m1_req = 0; mem_do = 32'h5555_1234;
      #1;
      nchk++;
      if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h5555_1234 ||
          m0_rvalid !== 1'b0) begin
         nerr++;
         $display("FAIL wr_rd_data: rv1 %b rd1 %h rv0 %b want 1 55551234 0",
                  m1_rvalid, m1_rdata, m0_rvalid);
      end
      @(negedge clk);
      idle();
   endtask

   // Model state: last owner, lock, run length, pending read.
   task automatic test_random();
      bit            pend[2];
      bit            lk[2];
      logic [AW-1:0] adr[2];
      logic [DW-1:0] wd[2];
      logic [3:0]    we[2];
      int            wait_c[2];
      int            ml, mlk, mh, mrp, e, o;
      bit            mrv;
      logic [AW-1:0] xa;
      logic [DW-1:0] xd, x0, x1;
      logic [3:0]    xw;
      do_reset();
      ml = 1; mlk = 0; mh = 0; mrv = 0; mrp = 0;
      for (int p = 0; p < 2; p++) begin
         pend[p] = 0; lk[p] = 0; adr[p] = '0; wd[p] = '0; we[p] = '0;
         wait_c[p] = 0;
      end
      for (int i = 0; i < 600; i++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && $urandom_range(0, 3) != 0) begin
               pend[p] = 1;
               adr[p]  = $urandom;
               wd[p]   = $urandom;
               we[p]   = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
               lk[p]   = ($urandom_range(0, 2) == 0);
               wait_c[p] = 0;
            end
         end
         m0_req = pend[0]; m0_lock = lk[0]; m0_adr = adr[0];
         m0_wdata = wd[0]; m0_wren = we[0];
         m1_req = pend[1]; m1_lock = lk[1]; m1_adr = adr[1];
         m1_wdata = wd[1]; m1_wren = we[1];
         mem_do = $urandom;
         #1;
         o = 1 - ml;
         e = -1;
         if (mh == MAXH && pend[o]) e = o;
         else if (mlk != 0 && pend[ml]) e = ml;
         else if (pend[0] && pend[1]) e = RR ? o : 0;
         else if (pend[0]) e = 0;
         else if (pend[1]) e = 1;
         xa = (e == 0) ? adr[0] : (e == 1) ? adr[1] : '0;
         xd = (e == 0) ? wd[0]  : (e == 1) ? wd[1]  : '0;
         xw = (e == 0) ? we[0]  : (e == 1) ? we[1]  : '0;
         x0 = (mrv && mrp == 0) ? mem_do : '0;
         x1 = (mrv && mrp == 1) ? mem_do : '0;
         nchk++;
         if ({m1_gnt, m0_gnt, mem_op} !== {e == 1, e == 0, e >= 0}) begin
            nerr++;
            $display("FAIL rnd_gnt c%0d: gnt %b%b op %b want port %0d",
                     i, m1_gnt, m0_gnt, mem_op, e);
         end
         nchk++;
         if (mem_adr !== xa || mem_di !== xd || mem_wren !== xw) begin
            nerr++;
            $display("FAIL rnd_bus c%0d: %h %h %h want %h %h %h",
                     i, mem_adr, mem_di, mem_wren, xa, xd, xw);
         end
         nchk++;
         if (m0_rvalid !== (mrv && mrp == 0) || m0_rdata !== x0 ||
             m1_rvalid !== (mrv && mrp == 1) || m1_rdata !== x1) begin
            nerr++;
            $display("FAIL rnd_rsp c%0d: rv %b%b rd %h %h want %h %h",
                     i, m1_rvalid, m0_rvalid, m0_rdata, m1_rdata, x0, x1);
         end
         if (e >= 0) begin
            nchk++;
            if (wait_c[e] > MAXH) begin
               nerr++;
               $display("FAIL rnd_starve c%0d: port %0d waited %0d want <= %0d",
                        i, e, wait_c[e], MAXH);
            end
            if (pend[1 - e]) mh = (e == ml) ? ((mh + 1 > MAXH) ? MAXH : mh + 1) : 1;
            else mh = 0;
            ml  = e;
            mlk = lk[e];
            mrv = (we[e] == 4'h0);
            mrp = e;
            pend[e] = 0;
         end else begin
            mlk = 0;
            mh  = 0;
            mrv = 0;
         end
         for (int p = 0; p < 2; p++) if (pend[p]) wait_c[p]++;
         @(negedge clk);
      end
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_read();
      test_tie();
      test_lock();
      test_reset_mid();
      test_wr_then_rd();
      test_random();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory bus arbiter that shares the single SoC memory bus (RAM, MMIO, ROM data port) between the UART debug unit (port 0) and the CPU data port (port 1). It replaces the hard debug-override mux with a registered arbitration state: per-cycle grant, lock for back-to-back accesses, and a starvation limiter. Read data is returned with the fixed one-cycle latency of the memory slaves.

## Interface
- AW, 32, address width
- DW, 32, data width
- MAX_HOLD, 8, maximum consecutive grants to one port while the other is requesting (1..255)

- clk  in  1  system clock
- n_reset  in  1  reset; one clock; reset is asynchronous and active-low
- m0_req / m1_req  in  1  access request; payload held stable until granted
- m0_lock / m1_lock  in  1  keep ownership for the following cycle if still requesting
- m0_adr / m1_adr  in  AW  byte address
- m0_wdata / m1_wdata  in  DW  write data
- m0_wren / m1_wren  in  4  byte write enables; 0 = read
- m0_gnt / m1_gnt  out  1  access accepted this cycle (address phase)
- m0_rvalid / m1_rvalid  out  1  read data valid (cycle after read grant)
- m0_rdata / m1_rdata  out  DW  read data, zero when rvalid low
- mem_op  out  1  bus access this cycle
- mem_adr  out  AW  muxed address
- mem_di  out  DW  muxed write data
- mem_wren  out  4  muxed byte enables
- mem_do  in  DW  OR-bus read data, valid cycle after mem_op

## Operation
- Grant is combinational from current requests and registered state (last, owner_locked, hold_cnt); at most one gnt per cycle.
- mem_op = m0_gnt | m1_gnt; mem_adr/di/wren taken from granted port, all zero when no grant.
- Selection order per cycle:
  1. hold_cnt == MAX_HOLD and other port requesting -> other port.
  2. owner_locked and owner requesting -> owner.
  3. one requester -> that port.
  4. both requesting -> policy (see Configuration).
- Registered on grant: last <= granted port; owner_locked <= granted port's lock; hold_cnt <= (same port as last and other port requested) ? hold_cnt+1 : 1 when other requested, else 0. Saturates at MAX_HOLD.
- No grant: owner_locked <= 0, hold_cnt <= 0, last unchanged.
- Read tracking: rd_pend <= granted & (wren == 0), rd_port <= granted port. Next cycle the matching mX_rvalid = 1, mX_rdata = mem_do; other port rdata = 0.
- Writes complete in the grant cycle; no response.

## Timing
- Reset: all gnt, rvalid, mem_op low; all data/address outputs zero; last = port 1 (so port 0 wins first tie); owner_locked = 0; hold_cnt = 0; rd_pend = 0.
- Read latency: gnt at cycle N, rvalid/rdata at N+1. Back-to-back reads from either port sustain one access per cycle.
- A port's req must not drop before gnt; payload sampled only in gnt cycle.
- Simultaneous new request and rvalid on the same port: allowed, independent.
- Lock held while other port requests still yields at MAX_HOLD; lock is not re-honoured until the owner is granted again.
- Reset asserted mid-operation: pending rvalid discarded, outputs to reset values immediately (async).

## Configuration
- MEM_ARBITER_RR_EN defined: ties resolved round-robin — port != last wins.
- Undefined: fixed priority — port 0 (debug) always wins ties; MAX_HOLD limiter still guarantees port 1 progress.

## Structure
- Shared package: port index constants (ARB_P0 = 0, ARB_P1 = 1) and the 4-bit byte-enable type, also used by the SoC top.
- No sub-module required; optional sub-module arb_hold_counter for the saturating hold counter.

## Test plan
- Port 1 read adr 0x2_0000, mem_do = 0x1234_5678 next cycle -> m1_gnt at N, m1_rvalid with 0x1234_5678 at N+1, m0 outputs zero.
- Both request from reset, no lock, RR undefined -> m0 granted every cycle for 8 cycles, then m1 granted once (MAX_HOLD=8), then m0 again.
- Both request continuously, MEM_ARBITER_RR_EN defined -> grants alternate 0,1,0,1; first grant to port 0.
- Port 1 lock=1 for 3 writes to 0x1_0010 while port 0 requests from cycle 1 -> m1 gets 3 consecutive grants, m0 granted on 4th; mem_wren = 4'b1111 during m1 grants.
- Port 0 read granted at N, n_reset low mid-cycle N+1 -> m0_rvalid, mem_op forced 0 immediately; after release, first tie goes to port 0.
- Port 0 write (wren=4'b0001) at N, port 1 read at N+1 -> no rvalid at N+1, m1_rvalid at N+2 with mem_do.
